// File: rtl/marquee_pkg.sv
// marquee_pkg: shared types and defaults for the marquee operator front-end.
//   state_e       - operator mode (ST_EDIT / ST_RUN)
//   DIGIT_W_DEF   - default bits per displayed digit
//   INIT_SEQ_DEF  - default sequence loaded at reset
//   digits()      - number of digits in an n-bit sequence
package marquee_pkg;

   typedef enum logic {ST_EDIT, ST_RUN} state_e;

   localparam int unsigned DIGIT_W_DEF  = 4;
   localparam logic [31:0] INIT_SEQ_DEF = 32'h0123_4567;

   function automatic int unsigned digits(input int unsigned n, input int unsigned w);
      return n / w;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, debounce counter and press pulse for one raw button.
//   clk    - clock
//   rst_n  - asynchronous active-low reset
//   btn    - raw, asynchronous button level
//   press  - registered one-cycle pulse on each accepted 0->1 transition
module btn_debounce #(
   parameter int unsigned DB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic press
);

   // Counter only needs to reach DB_CYCLES-1; the flip happens on the next differing cycle.
   localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

   logic [1:0]       sync_q;
   logic             stable_q, stable_d;
   logic             stable_prev_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             press_q;

   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync_q[1] != stable_q) begin
         if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
            stable_d = ~stable_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q        <= '0;
         stable_q      <= 1'b0;
         stable_prev_q <= 1'b0;
         cnt_q         <= '0;
         press_q       <= 1'b0;
      end else begin
         sync_q        <= {sync_q[0], btn};
         stable_q      <= stable_d;
         cnt_q         <= cnt_d;
         stable_prev_q <= stable_q;
         press_q       <= stable_q & ~stable_prev_q;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/marquee_input.sv
// marquee_input: operator front-end producing registered seq/enable/dir for the marquee display.
//   sys_clk    - clock
//   sys_rst_n  - asynchronous active-low reset
//   sw         - digit value to write (quasi-static)
//   btn_load   - raw button: write sw at cursor (EDIT only)
//   btn_run    - raw button: toggle EDIT/RUN
//   btn_dir    - raw button: toggle scroll direction
//   seq        - displayed sequence
//   enable     - scroll enable (RUN)
//   dir        - scroll direction, 1 = right
//   cursor     - digit index being edited
//   editing    - high in EDIT
// Build option: MARQUEE_INPUT_SHIFT_ENTRY_EN makes a load shift seq left one digit and insert sw
// at digit 0 instead of writing at the cursor.
module marquee_input
   import marquee_pkg::*;
#(
   parameter int unsigned N         = 32,
   parameter int unsigned DIGIT_W   = DIGIT_W_DEF,
   parameter int unsigned DB_CYCLES = 1_000_000,
   parameter logic [N-1:0] INIT_SEQ = INIT_SEQ_DEF
) (
   input  logic                          sys_clk,
   input  logic                          sys_rst_n,
   input  logic [DIGIT_W-1:0]            sw,
   input  logic                          btn_load,
   input  logic                          btn_run,
   input  logic                          btn_dir,
   output logic [N-1:0]                  seq,
   output logic                          enable,
   output logic                          dir,
   output logic [$clog2(N/DIGIT_W)-1:0]  cursor,
   output logic                          editing
);

   localparam int unsigned DIGITS = digits(N, DIGIT_W);
   localparam int unsigned CUR_W  = $clog2(DIGITS);

   logic load_p, run_p, dir_p;

   state_e           state_q, state_d;
   logic [N-1:0]     seq_q, seq_d;
   logic [CUR_W-1:0] cursor_q, cursor_d;
   logic             dir_q, dir_d;
   logic             enable_q, editing_q;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_load (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .btn   (btn_load),
      .press (load_p)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .btn   (btn_run),
      .press (run_p)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dir (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .btn   (btn_dir),
      .press (dir_p)
   );

   always_comb begin
      state_d  = state_q;
      seq_d    = seq_q;
      cursor_d = cursor_q;
      dir_d    = dir_q ^ dir_p;
      unique case (state_q)
         ST_EDIT: begin
            if (load_p) begin
`ifdef MARQUEE_INPUT_SHIFT_ENTRY_EN
               seq_d = {seq_q[N-DIGIT_W-1:0], sw};
`else
               seq_d[int'(cursor_q) * DIGIT_W +: DIGIT_W] = sw;
               if (cursor_q == CUR_W'(DIGITS - 1)) begin
                  cursor_d = '0;
               end else begin
                  cursor_d = cursor_q + 1'b1;
               end
`endif
            end
            if (run_p) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (run_p) begin
               state_d = ST_EDIT;
            end
         end
         default: state_d = ST_EDIT;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q   <= ST_EDIT;
         seq_q     <= INIT_SEQ;
         cursor_q  <= '0;
         dir_q     <= 1'b0;
         enable_q  <= 1'b0;
         editing_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         seq_q     <= seq_d;
         cursor_q  <= cursor_d;
         dir_q     <= dir_d;
         // Mode flags registered from next state so they track state_q exactly.
         enable_q  <= (state_d == ST_RUN);
         editing_q <= (state_d == ST_EDIT);
      end
   end

   assign seq     = seq_q;
   assign enable  = enable_q;
   assign dir     = dir_q;
   assign cursor  = cursor_q;
   assign editing = editing_q;

endmodule

// File: tb/tb_marquee_input.sv
// tb_marquee_input: directed self-checking bench for marquee_input with DB_CYCLES = 4.
module tb_marquee_input;

`ifdef MARQUEE_INPUT_SHIFT_ENTRY_EN
   localparam bit SHIFT = 1'b1;
`else
   localparam bit SHIFT = 1'b0;
`endif

   logic        sys_clk = 1'b0;
   logic        sys_rst_n;
   logic [3:0]  sw;
   logic        btn_load, btn_run, btn_dir;
   logic [31:0] seq;
   logic        enable, dir, editing;
   logic [2:0]  cursor;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   marquee_input #(
      .N         (32),
      .DIGIT_W   (4),
      .DB_CYCLES (4)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .sw        (sw),
      .btn_load  (btn_load),
      .btn_run   (btn_run),
      .btn_dir   (btn_dir),
      .seq       (seq),
      .enable    (enable),
      .dir       (dir),
      .cursor    (cursor),
      .editing   (editing)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   // Full press: hold long enough to be accepted, release and let the release settle.
   task automatic press(input bit l, input bit r, input bit d);
      btn_load = l;
      btn_run  = r;
      btn_dir  = d;
      cycles(9);
      btn_load = 1'b0;
      btn_run  = 1'b0;
      btn_dir  = 1'b0;
      cycles(9);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_seq"},     seq, 32'h0123_4567);
      check({tag, "_enable"},  32'(enable), 32'd0);
      check({tag, "_dir"},     32'(dir), 32'd0);
      check({tag, "_cursor"},  32'(cursor), 32'd0);
      check({tag, "_editing"}, 32'(editing), 32'd1);
   endtask

   initial begin
      sys_rst_n = 1'b0;
      sw        = 4'h0;
      btn_load  = 1'b0;
      btn_run   = 1'b0;
      btn_dir   = 1'b0;
      cycles(3);
      sys_rst_n = 1'b1;
      cycles(1);
      check_reset("rst");

      // Single held load: effect lands exactly on edge 8, only once.
      sw       = 4'hA;
      btn_load = 1'b1;
      cycles(7);
      check("load_edge7_seq", seq, 32'h0123_4567);
      cycles(1);
      check("load_edge8_seq", seq, SHIFT ? 32'h1234_567A : 32'h0123_456A);
      check("load_edge8_cursor", 32'(cursor), SHIFT ? 32'd0 : 32'd1);
      cycles(2);
      btn_load = 1'b0;
      cycles(12);
      check("load_once_seq", seq, SHIFT ? 32'h1234_567A : 32'h0123_456A);
      check("load_once_cursor", 32'(cursor), SHIFT ? 32'd0 : 32'd1);

      // Glitch of 3 cycles must be rejected.
      sw       = 4'h5;
      btn_load = 1'b1;
      cycles(3);
      btn_load = 1'b0;
      cycles(12);
      check("glitch_seq", seq, SHIFT ? 32'h1234_567A : 32'h0123_456A);
      check("glitch_cursor", 32'(cursor), SHIFT ? 32'd0 : 32'd1);

      // Seven F loads fill digits 1..7 and wrap the cursor to 0, the eighth hits digit 0.
      sw = 4'hF;
      for (int i = 0; i < 7; i++) press(1'b1, 1'b0, 1'b0);
      check("fill7_seq", seq, SHIFT ? 32'hAFFF_FFFF : 32'hFFFF_FFFA);
      check("fill7_cursor_wrap", 32'(cursor), 32'd0);
      press(1'b1, 1'b0, 1'b0);
      check("fill8_seq", seq, 32'hFFFF_FFFF);
      check("fill8_cursor", 32'(cursor), SHIFT ? 32'd0 : 32'd1);

      // RUN mode: load ignored, cursor kept across return to EDIT.
      press(1'b0, 1'b1, 1'b0);
      check("run_enable", 32'(enable), 32'd1);
      check("run_editing", 32'(editing), 32'd0);
      sw = 4'h3;
      press(1'b1, 1'b0, 1'b0);
      check("run_load_seq", seq, 32'hFFFF_FFFF);
      check("run_load_cursor", 32'(cursor), SHIFT ? 32'd0 : 32'd1);
      press(1'b0, 1'b1, 1'b0);
      check("edit_enable", 32'(enable), 32'd0);
      check("edit_editing", 32'(editing), 32'd1);
      check("edit_cursor", 32'(cursor), SHIFT ? 32'd0 : 32'd1);

      // dir and load together in EDIT take effect on the same edge.
      sw       = 4'h5;
      btn_load = 1'b1;
      btn_dir  = 1'b1;
      cycles(7);
      check("dirload_edge7_dir", 32'(dir), 32'd0);
      cycles(1);
      check("dirload_dir", 32'(dir), 32'd1);
      check("dirload_seq", seq, SHIFT ? 32'hFFFF_FFF5 : 32'hFFFF_FF5F);
      check("dirload_cursor", 32'(cursor), SHIFT ? 32'd0 : 32'd2);
      btn_load = 1'b0;
      btn_dir  = 1'b0;
      cycles(9);

      // load and run together in EDIT: write, advance and enter RUN.
      sw = 4'h6;
      press(1'b1, 1'b1, 1'b0);
      check("loadrun_seq", seq, SHIFT ? 32'hFFFF_FF56 : 32'hFFFF_F65F);
      check("loadrun_cursor", 32'(cursor), SHIFT ? 32'd0 : 32'd3);
      check("loadrun_enable", 32'(enable), 32'd1);

      // dir toggles in RUN too.
      press(1'b0, 1'b0, 1'b1);
      check("run_dir", 32'(dir), 32'd0);
      check("run_dir_enable", 32'(enable), 32'd1);

      // Reset mid-RUN forces reset values immediately, with a load held through release.
      @(posedge sys_clk);
      #2;
      sys_rst_n = 1'b0;
      btn_load  = 1'b1;
      sw        = 4'h9;
      #1;
      check_reset("midrst");
      cycles(2);
      sys_rst_n = 1'b1;
      cycles(7);
      check("held_edge7_seq", seq, 32'h0123_4567);
      cycles(1);
      check("held_edge8_seq", seq, SHIFT ? 32'h1234_5679 : 32'h0123_4569);
      check("held_edge8_cursor", 32'(cursor), SHIFT ? 32'd0 : 32'd1);
      btn_load = 1'b0;
      cycles(10);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/marquee_input.md
# marquee_input

Operator front-end for the marquee display. It takes the board's raw push-buttons and 4-bit slide switches and turns them into the registered `seq`, `enable` and `dir` values that the marquee display stage consumes. It lets the operator edit the displayed hex sequence one digit at a time, start and stop scrolling, and flip the scroll direction. Raw buttons are synchronized and debounced inside the block.

## Interface
Parameters:
- `N`, default 32: sequence width in bits; must be a multiple of `DIGIT_W`.
- `DIGIT_W`, default 4: bits per displayed digit.
- `DB_CYCLES`, default 1_000_000: consecutive stable `sys_clk` cycles needed to accept a button level; 4 in simulation.
- `INIT_SEQ`, default `32'h0123_4567`: value of `seq` at reset.

Ports:
- `sys_clk`, in, 1: the single clock.
- `sys_rst_n`, in, 1: reset; asynchronous, active-low.
- `sw`, in, `DIGIT_W`: digit value to write; quasi-static and not synchronized.
- `btn_load`, in, 1: raw button; write `sw` into the digit under the cursor.
- `btn_run`, in, 1: raw button; toggle between EDIT and RUN.
- `btn_dir`, in, 1: raw button; toggle scroll direction.
- `seq`, out, `N`: sequence to display.
- `enable`, out, 1: scroll enable; high only in RUN.
- `dir`, out, 1: 1 = right, 0 = left.
- `cursor`, out, `$clog2(N/DIGIT_W)`: index of the digit being edited (digit 0 = bits [3:0]).
- `editing`, out, 1: high in EDIT.

## Operation
- Each raw button goes through a 2-flop synchronizer and then a debouncer.
  - The debouncer holds a stable level.
  - Its counter increments while the synchronized input differs from the stable level and clears on any cycle they match.
  - When the count reaches `DB_CYCLES`, the stable level flips and the counter clears.
  - A one-cycle registered press pulse fires on each 0->1 stable transition. Release generates no pulse.
- FSM states:
  - EDIT (reset state):
    - load pulse: `seq[cursor*DIGIT_W +: DIGIT_W] <= sw`, and `cursor <= cursor+1`, wrapping from `N/DIGIT_W-1` to 0.
    - run pulse: go to RUN.
  - RUN:
    - `enable=1`.
    - load pulse is ignored; `seq` and `cursor` are frozen.
    - run pulse: go to EDIT. `cursor` keeps its value.
- dir pulse toggles `dir` in either state.
- Simultaneous pulses in the same cycle each take effect independently.
  - In EDIT, load plus run: the digit write and cursor advance happen, and the state becomes RUN.
  - dir plus anything: the toggle always happens.
- Width rules:
  - `cursor` wraps modulo `N/DIGIT_W`.
  - The `seq` write touches only the addressed digit; all other bits are held.
- Reset values: `seq=INIT_SEQ`, `enable=0`, `dir=0`, `cursor=0`, `editing=1`, state EDIT. Debouncer stable levels, counters and synchronizers are all 0.
- Reset asserted mid-debounce or mid-RUN immediately forces these values. A button held through reset release produces a pulse after the normal debounce time.

## Timing
- All outputs are registered.
- Raw button rises and is held; edge 1 is the first edge sampling it high:
  - the synchronizer output is high after edge 2;
  - the stable level flips at edge `DB_CYCLES+2`;
  - the press pulse is high after edge `DB_CYCLES+3`;
  - the output effect is visible after edge `DB_CYCLES+4`.
  - With `DB_CYCLES=4`, `seq`, `cursor`, `state` and `dir` update at edge 8.
- A glitch shorter than `DB_CYCLES` synchronized cycles produces no pulse.
- Holding a button produces exactly one pulse; there is no auto-repeat.

## Configuration
- `MARQUEE_INPUT_SHIFT_ENTRY_EN`:
  - Defined: a load pulse in EDIT performs `seq <= {seq[N-DIGIT_W-1:0], sw}`, i.e. shift left one digit and insert at digit 0. `cursor` stays 0.
  - Undefined: cursor-addressed write as described under Operation.

## Structure
- Package `marquee_pkg`:
  - state enum `{ST_EDIT, ST_RUN}`;
  - `DIGIT_W` default;
  - `DIGITS = N/DIGIT_W` helper;
  - default `INIT_SEQ`.
- Sub-module `btn_debounce` (synchronizer + debounce counter + press-pulse), parameterized by `DB_CYCLES` and instantiated three times.

## Test plan
(`DB_CYCLES=4`)
- Reset released -> `seq=32'h01234567`, `enable=0`, `dir=0`, `cursor=0`, `editing=1`.
- `sw=4'hA`, `btn_load` held 10 cycles -> after edge 8, `seq=32'h0123456A`, `cursor=1`, exactly one update.
- `btn_load` glitch of 3 cycles -> no change to `seq` or `cursor`.
- 8 load presses with `sw=4'hF` -> `seq=32'hFFFFFFFF`, `cursor` wraps back to 0.
- `btn_run` press -> `enable=1`, `editing=0`. Load press in RUN -> `seq` unchanged. Second `btn_run` -> `enable=0`, `cursor` preserved.
- `btn_dir` and `btn_load` pressed in the same cycle in EDIT -> `dir=1` and the digit is written in the same cycle. With `MARQUEE_INPUT_SHIFT_ENTRY_EN`, `sw=4'h9` from reset -> `seq=32'h12345679`.
